// File: rtl/sd_sb_initiator.sv
// sd_sb_initiator
//   Host-side front end for a tagged scoreboard. Read requests get the
//   lowest free transaction id (txid), and the host item id is remembered
//   per txid. When the scoreboard answers, the stored item id is paired with
//   the returned data. Update requests pass straight through with txid 0 and
//   expect no answer.
//
// Parameters
//   width    data/mask bit width
//   items    scoreboard entry count
//   txid_sz  transaction-id width (2**txid_sz tags)
//   asz      item-id width
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   c_*                        host request (c_req_type 1=update, 0=read)
//   p_*                        request towards the scoreboard (registered)
//   r_*                        scoreboard read response
//   o_*                        read return to host (registered)
//   outstanding                number of reads in flight
//   err                        sticky unknown-txid flag
//
// Build option
//   SD_SB_INIT_ERRCHK_EN       when defined, responses carrying a txid that is
//                              not in flight are swallowed and set err until
//                              reset. Otherwise err is 0 and every response
//                              is forwarded.

module sd_sb_initiator #(
  parameter int width   = 32,
  parameter int items   = 32,
  parameter int txid_sz = 5,
  parameter int asz     = $clog2(items)
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic               c_req_type,
  input  logic [width-1:0]   c_mask,
  input  logic [width-1:0]   c_data,
  input  logic [asz-1:0]     c_itemid,

  output logic               p_srdy,
  input  logic               p_drdy,
  output logic               p_req_type,
  output logic [txid_sz-1:0] p_txid,
  output logic [width-1:0]   p_mask,
  output logic [width-1:0]   p_data,
  output logic [asz-1:0]     p_itemid,

  input  logic               r_srdy,
  output logic               r_drdy,
  input  logic [txid_sz-1:0] r_txid,
  input  logic [width-1:0]   r_data,

  output logic               o_srdy,
  input  logic               o_drdy,
  output logic [asz-1:0]     o_itemid,
  output logic [width-1:0]   o_data,

  output logic [txid_sz:0]   outstanding,
  output logic               err
);

  localparam int ntags = 2 ** txid_sz;

  logic [ntags-1:0]   busy;
  logic [asz-1:0]     tag_table [ntags];

  logic [txid_sz-1:0] free_id;
  logic               txid_free;
  logic               c_accept;
  logic               rd_alloc;
  logic               r_accept;
  logic               r_forward;
  logic [ntags-1:0]   busy_set;
  logic [ntags-1:0]   busy_clr;
  logic [txid_sz:0]   busy_count;

  // Lowest-numbered free tag. Scanning downward lets the lowest index win.
  always_comb begin
    free_id   = '0;
    txid_free = 1'b0;
    for (int i = ntags - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_id   = txid_sz'(i);
        txid_free = 1'b1;
      end
    end
  end

  // Reads additionally need a free tag; updates only need buffer space.
  assign c_drdy   = (~p_srdy | p_drdy) & (c_req_type | txid_free);
  assign c_accept = c_srdy & c_drdy;
  assign rd_alloc = c_accept & ~c_req_type;

  assign r_drdy   = ~o_srdy | o_drdy;
  assign r_accept = r_srdy & r_drdy;

`ifdef SD_SB_INIT_ERRCHK_EN
  logic r_known;
  assign r_known   = busy[r_txid];
  assign r_forward = r_accept & r_known;
`else
  assign r_forward = r_accept;
  assign err       = 1'b0;
`endif

  // Allocation looks at the registered busy vector, so a tag freed on this
  // edge only becomes allocatable from the next edge on. The allocated tag
  // is never the one being freed because it is not busy now.
  assign busy_set = rd_alloc ? ({{(ntags-1){1'b0}}, 1'b1} << free_id) : '0;
  assign busy_clr = r_accept ? ({{(ntags-1){1'b0}}, 1'b1} << r_txid)  : '0;

  // Reads in flight is simply the number of busy tags.
  always_comb begin
    busy_count = '0;
    for (int i = 0; i < ntags; i++) begin
      busy_count = busy_count + (txid_sz+1)'(busy[i]);
    end
  end
  assign outstanding = busy_count;

  // Control state: tag ownership and the two buffer valid flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= '0;
      p_srdy <= 1'b0;
      o_srdy <= 1'b0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
      if (c_accept)
        p_srdy <= 1'b1;
      else if (p_drdy)
        p_srdy <= 1'b0;
      if (r_forward)
        o_srdy <= 1'b1;
      else if (o_drdy)
        o_srdy <= 1'b0;
    end
  end

`ifdef SD_SB_INIT_ERRCHK_EN
  // Sticky flag for responses whose txid is not currently in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err <= 1'b0;
    else if (r_accept && !r_known)
      err <= 1'b1;
  end
`endif

  // Payload registers and the txid table carry no reset; their contents are
  // only meaningful while the matching valid flag or busy bit is set.
  always_ff @(posedge clk) begin
    if (c_accept) begin
      p_req_type <= c_req_type;
      p_txid     <= c_req_type ? '0 : free_id;
      p_mask     <= c_mask;
      p_data     <= c_data;
      p_itemid   <= c_itemid;
    end
    if (rd_alloc)
      tag_table[free_id] <= c_itemid;
    if (r_forward) begin
      o_data   <= r_data;
      o_itemid <= tag_table[r_txid];
    end
  end

endmodule

// File: tb/tb_sd_sb_initiator.sv
// tb_sd_sb_initiator
//   Directed bench for sd_sb_initiator at default parameters. A transaction
//   level model (tag set, tag table, request and return queues) predicts the
//   outputs and is compared against the DUT on every falling edge; directed
//   scenarios add hand-computed literal expectations on top.

module tb_sd_sb_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_srdy, c_req_type;
  logic [31:0] c_mask, c_data;
  logic [4:0]  c_itemid;
  logic        c_drdy;
  logic        p_srdy, p_drdy, p_req_type;
  logic [4:0]  p_txid, p_itemid;
  logic [31:0] p_mask, p_data;
  logic        r_srdy, r_drdy;
  logic [4:0]  r_txid;
  logic [31:0] r_data;
  logic        o_srdy, o_drdy;
  logic [4:0]  o_itemid;
  logic [31:0] o_data;
  logic [5:0]  outstanding;
  logic        err;

  int checks   = 0;
  int failures = 0;

  sd_sb_initiator dut (
    .clk(clk), .reset(reset),
    .c_srdy(c_srdy), .c_drdy(c_drdy), .c_req_type(c_req_type),
    .c_mask(c_mask), .c_data(c_data), .c_itemid(c_itemid),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_req_type(p_req_type),
    .p_txid(p_txid), .p_mask(p_mask), .p_data(p_data), .p_itemid(p_itemid),
    .r_srdy(r_srdy), .r_drdy(r_drdy), .r_txid(r_txid), .r_data(r_data),
    .o_srdy(o_srdy), .o_drdy(o_drdy), .o_itemid(o_itemid), .o_data(o_data),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  // Transaction-level model of the block
  typedef struct {
    logic        typ;
    logic [4:0]  txid;
    logic [31:0] mask;
    logic [31:0] data;
    logic [4:0]  itemid;
  } p_item_t;

  typedef struct {
    logic [4:0]  itemid;
    logic [31:0] data;
  } o_item_t;

  bit [31:0]  m_busy = '0;
  logic [4:0] m_tab [32];
  p_item_t    p_q[$];
  o_item_t    o_q[$];
  bit         m_err = 1'b0;

  function automatic int m_lowest_free();
    for (int i = 0; i < 32; i++)
      if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic bit m_c_ready();
    bit room;
    room = (p_q.size() == 0) || p_drdy;
    return room && (c_req_type || ($countones(m_busy) < 32));
  endfunction

  function automatic bit m_r_ready();
    return (o_q.size() == 0) || o_drdy;
  endfunction

  task automatic model_step();
    bit      c_ok, p_take, r_ok, o_take, known;
    int      tag;
    p_item_t pi;
    o_item_t oi;
    c_ok   = c_srdy && m_c_ready();
    p_take = (p_q.size() != 0) && p_drdy;
    r_ok   = r_srdy && m_r_ready();
    o_take = (o_q.size() != 0) && o_drdy;
    tag    = m_lowest_free();
    known  = m_busy[r_txid];
    if (o_take) o_q.delete(0);
    if (r_ok) begin
      oi.itemid = m_tab[r_txid];
      oi.data   = r_data;
`ifdef SD_SB_INIT_ERRCHK_EN
      if (known) o_q.push_back(oi);
      else       m_err = 1'b1;
`else
      o_q.push_back(oi);
`endif
      m_busy[r_txid] = 1'b0;
    end
    if (p_take) p_q.delete(0);
    if (c_ok) begin
      pi.typ    = c_req_type;
      pi.mask   = c_mask;
      pi.data   = c_data;
      pi.itemid = c_itemid;
      if (!c_req_type) begin
        m_busy[tag] = 1'b1;
        m_tab[tag]  = c_itemid;
        pi.txid     = 5'(tag);
      end else begin
        pi.txid = 5'd0;
      end
      p_q.push_back(pi);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_busy = '0;
        p_q.delete();
        o_q.delete();
        m_err = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] got,
                              input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare every output against the model away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      check_output("m_c_drdy", 64'(c_drdy), 64'(m_c_ready()));
      check_output("m_r_drdy", 64'(r_drdy), 64'(m_r_ready()));
      check_output("m_p_srdy", 64'(p_srdy), 64'(p_q.size() != 0));
      if (p_q.size() != 0) begin
        check_output("m_p_req_type", 64'(p_req_type), 64'(p_q[0].typ));
        check_output("m_p_txid",     64'(p_txid),     64'(p_q[0].txid));
        check_output("m_p_mask",     64'(p_mask),     64'(p_q[0].mask));
        check_output("m_p_data",     64'(p_data),     64'(p_q[0].data));
        check_output("m_p_itemid",   64'(p_itemid),   64'(p_q[0].itemid));
      end
      check_output("m_o_srdy", 64'(o_srdy), 64'(o_q.size() != 0));
      if (o_q.size() != 0) begin
        check_output("m_o_itemid", 64'(o_itemid), 64'(o_q[0].itemid));
        check_output("m_o_data",   64'(o_data),   64'(o_q[0].data));
      end
      check_output("m_outstanding", 64'(outstanding), 64'($countones(m_busy)));
      check_output("m_err", 64'(err), 64'(m_err));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change only just after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one host request and hold it until it is accepted.
  task automatic apply_stimulus(input logic typ, input logic [4:0] id,
                                input logic [31:0] m, input logic [31:0] d);
    c_srdy = 1'b1; c_req_type = typ; c_itemid = id; c_mask = m; c_data = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (c_drdy) begin
        step();
        c_srdy = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("[TB] FAIL c_accept_timeout got=0 expected=1");
    c_srdy = 1'b0;
  endtask

  // Present one scoreboard response and hold it until it is accepted.
  task automatic send_rsp(input logic [4:0] id, input logic [31:0] d);
    r_srdy = 1'b1; r_txid = id; r_data = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (r_drdy) begin
        step();
        r_srdy = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("[TB] FAIL r_accept_timeout got=0 expected=1");
    r_srdy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c_srdy = 1'b0; r_srdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("rst_c_drdy", 64'(c_drdy), 64'd1);
    check_output("rst_r_drdy", 64'(r_drdy), 64'd1);
    check_output("rst_p_srdy", 64'(p_srdy), 64'd0);
    check_output("rst_o_srdy", 64'(o_srdy), 64'd0);
    check_output("rst_outstanding", 64'(outstanding), 64'd0);
    check_output("rst_err", 64'(err), 64'd0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    c_srdy = 1'b0; c_req_type = 1'b0; c_mask = '0; c_data = '0; c_itemid = '0;
    p_drdy = 1'b1; r_srdy = 1'b0; r_txid = '0; r_data = '0; o_drdy = 1'b1;
    #2;
    do_reset();

    // Single read round trip
    apply_stimulus(1'b0, 5'd7, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    check_output("rd7_p_srdy", 64'(p_srdy), 64'd1);
    check_output("rd7_p_txid", 64'(p_txid), 64'd0);
    check_output("rd7_p_itemid", 64'(p_itemid), 64'd7);
    check_output("rd7_outstanding", 64'(outstanding), 64'd1);
    step();
    send_rsp(5'd0, 32'hDEADBEEF);
    @(negedge clk);
    check_output("rd7_o_srdy", 64'(o_srdy), 64'd1);
    check_output("rd7_o_itemid", 64'(o_itemid), 64'd7);
    check_output("rd7_o_data", 64'(o_data), 64'hDEADBEEF);
    check_output("rd7_outstanding0", 64'(outstanding), 64'd0);
    step();

    // Fill all 32 tags, then a read stalls while an update still passes
    for (int i = 0; i < 32; i++)
      apply_stimulus(1'b0, 5'(i), 32'h0000_00FF, 32'(i * 3));
    @(negedge clk);
    check_output("full_outstanding", 64'(outstanding), 64'd32);
    step();
    c_srdy = 1'b1; c_req_type = 1'b0; c_itemid = 5'd1;
    @(negedge clk);
    check_output("full_rd_c_drdy", 64'(c_drdy), 64'd0);
    step();
    step();
    apply_stimulus(1'b1, 5'd5, 32'h0000_F0F0, 32'h0000_1234);
    @(negedge clk);
    check_output("full_upd_p_req_type", 64'(p_req_type), 64'd1);
    check_output("full_upd_p_txid", 64'(p_txid), 64'd0);
    check_output("full_upd_p_data", 64'(p_data), 64'h1234);
    check_output("full_upd_outstanding", 64'(outstanding), 64'd32);
    step();
    for (int i = 0; i < 32; i++)
      send_rsp(5'(i), 32'hA000 + 32'(i));
    @(negedge clk);
    check_output("drain_o_itemid", 64'(o_itemid), 64'd31);
    check_output("drain_outstanding", 64'(outstanding), 64'd0);
    step();

    // Response to a tag that is not in flight
    send_rsp(5'd9, 32'h99);
    @(negedge clk);
`ifdef SD_SB_INIT_ERRCHK_EN
    check_output("unk_o_srdy", 64'(o_srdy), 64'd0);
    check_output("unk_err", 64'(err), 64'd1);
    step(); step();
    @(negedge clk);
    check_output("unk_err_sticky", 64'(err), 64'd1);
`else
    check_output("unk_o_srdy", 64'(o_srdy), 64'd1);
    check_output("unk_o_itemid", 64'(o_itemid), 64'd9);
    check_output("unk_err", 64'(err), 64'd0);
`endif
    step();
    do_reset();

    // Out-of-order responses
    apply_stimulus(1'b0, 5'd20, 32'h1, 32'h20);
    apply_stimulus(1'b0, 5'd21, 32'h1, 32'h21);
    apply_stimulus(1'b0, 5'd22, 32'h1, 32'h22);
    @(negedge clk);
    check_output("ooo_p_txid2", 64'(p_txid), 64'd2);
    step();
    send_rsp(5'd2, 32'hB2);
    @(negedge clk);
    check_output("ooo_o_itemid_a", 64'(o_itemid), 64'd22);
    step();
    send_rsp(5'd0, 32'hB0);
    @(negedge clk);
    check_output("ooo_o_itemid_b", 64'(o_itemid), 64'd20);
    step();
    send_rsp(5'd1, 32'hB1);
    @(negedge clk);
    check_output("ooo_o_itemid_c", 64'(o_itemid), 64'd21);
    check_output("ooo_outstanding", 64'(outstanding), 64'd0);
    step();

    // Host return stalled with two responses pending
    o_drdy = 1'b0;
    apply_stimulus(1'b0, 5'd3, 32'h1, 32'h3);
    apply_stimulus(1'b0, 5'd4, 32'h1, 32'h4);
    r_srdy = 1'b1; r_txid = 5'd0; r_data = 32'hAAAA_0000;
    @(negedge clk);
    check_output("stall_r_drdy_first", 64'(r_drdy), 64'd1);
    step();
    r_txid = 5'd1; r_data = 32'hBBBB_0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("stall_r_drdy", 64'(r_drdy), 64'd0);
      check_output("stall_o_data", 64'(o_data), 64'hAAAA_0000);
      step();
    end
    o_drdy = 1'b1;
    step();
    r_srdy = 1'b0;
    @(negedge clk);
    check_output("stall_o_itemid_b", 64'(o_itemid), 64'd4);
    check_output("stall_o_data_b", 64'(o_data), 64'hBBBB_0001);
    check_output("stall_outstanding", 64'(outstanding), 64'd0);
    step();

    // Reset in the middle of traffic with four reads in flight
    apply_stimulus(1'b0, 5'd10, 32'h1, 32'h10);
    apply_stimulus(1'b0, 5'd11, 32'h1, 32'h11);
    apply_stimulus(1'b0, 5'd12, 32'h1, 32'h12);
    step();
    p_drdy = 1'b0;
    apply_stimulus(1'b0, 5'd13, 32'h1, 32'h13);
    step(); step();
    @(negedge clk);
    check_output("mid_p_srdy", 64'(p_srdy), 64'd1);
    check_output("mid_p_itemid", 64'(p_itemid), 64'd13);
    check_output("mid_outstanding", 64'(outstanding), 64'd4);
    #2 reset = 1'b1;
    #1;
    check_output("mid_rst_outstanding", 64'(outstanding), 64'd0);
    check_output("mid_rst_p_srdy", 64'(p_srdy), 64'd0);
    p_drdy = 1'b1;
    do_reset();
    send_rsp(5'd1, 32'h5151);
    @(negedge clk);
`ifdef SD_SB_INIT_ERRCHK_EN
    check_output("stale_o_srdy", 64'(o_srdy), 64'd0);
    check_output("stale_err", 64'(err), 64'd1);
`else
    check_output("stale_o_srdy", 64'(o_srdy), 64'd1);
    check_output("stale_o_itemid", 64'(o_itemid), 64'd11);
`endif
    step();
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_sb_initiator.md
SD_SB_INITIATOR -- requirements
Module: sd_sb_initiator

Interface
REQ-001 SHALL have parameter width, default 32, meaning data/mask bit width.
REQ-002 SHALL have parameter items, default 32, meaning scoreboard entry count.
REQ-003 SHALL have parameter txid_sz, default 5, meaning transaction-id width; 2**txid_sz tags.
REQ-004 SHALL have parameter asz, default $clog2(items), meaning item-id width.
REQ-005 SHALL have port clk, input, 1, meaning sole clock, all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have ports c_srdy in 1, c_drdy out 1, c_req_type in 1 (1=update, 0=read), c_mask in width, c_data in width, c_itemid in asz, meaning host request.
REQ-008 SHALL have ports p_srdy out 1, p_drdy in 1, p_req_type out 1, p_txid out txid_sz, p_mask out width, p_data out width, p_itemid out asz, meaning request to scoreboard.
REQ-009 SHALL have ports r_srdy in 1, r_drdy out 1, r_txid in txid_sz, r_data in width, meaning scoreboard read response.
REQ-010 SHALL have ports o_srdy out 1, o_drdy in 1, o_itemid out asz, o_data out width, meaning read return to host.
REQ-011 SHALL have ports outstanding out txid_sz+1 (reads in flight) and err out 1 (sticky unknown-txid flag).

Function
REQ-012 SHALL transfer on any interface only in a cycle where srdy and drdy are both 1.
REQ-013 SHALL hold a one-entry registered p_* buffer; c_drdy = (~p_srdy | p_drdy) & (c_req_type | txid_free).
REQ-014 SHALL, on an accepted read, allocate the lowest-numbered free txid, set its busy bit, store c_itemid in a txid-indexed table, and present the request on p_* the next cycle (latency 1).
REQ-015 SHALL forward accepted updates with p_txid = 0, allocate no txid, and expect no response.
REQ-016 SHALL keep p_* stable while p_srdy=1 and p_drdy=0.
REQ-017 SHALL hold a one-entry registered o_* buffer; r_drdy = ~o_srdy | o_drdy.
REQ-018 SHALL, on an accepted response, load o_data = r_data and o_itemid = table[r_txid], assert o_srdy the next cycle, and clear busy[r_txid] that same edge.
REQ-019 SHALL compute busy update as set-before-clear-visible: a txid freed at edge N is allocatable only by requests accepted at edge N+1 or later.
REQ-020 SHALL, when all 2**txid_sz tags are busy, deassert c_drdy for reads while still accepting updates.
REQ-021 SHALL update outstanding = popcount(busy) each cycle; simultaneous allocate and free leaves it unchanged.
REQ-022 SHALL accept responses in any txid order.

Reset
REQ-023 SHALL, on reset assertion at any time, clear busy, p_srdy, o_srdy, outstanding and err asynchronously; data/table registers need not be reset.
REQ-024 SHALL treat responses arriving after a mid-operation reset as unknown-txid responses (REQ-026).
REQ-025 SHALL drive c_drdy = 1 and r_drdy = 1 the first cycle after reset release.

Configuration
REQ-026 SHALL, with SD_SB_INIT_ERRCHK_EN defined, drop (accept, not forward) any response whose txid is not busy and set err=1 until reset.
REQ-027 SHALL, without SD_SB_INIT_ERRCHK_EN, tie err to 0 and forward every response using the stored table entry, clearing busy regardless.

Verification
REQ-028 SHALL cover: read itemid=7 after reset, p_drdy=1 -> p_txid=0, p_itemid=7 one cycle later; respond r_txid=0 r_data=0xDEADBEEF -> o_itemid=7, o_data=0xDEADBEEF next cycle, outstanding 1->0.
REQ-029 SHALL cover: 32 reads with responses withheld -> outstanding=32, c_drdy=0 for read 33, update with c_req_type=1 still accepted with p_txid=0.
REQ-030 SHALL cover: txids 0,1,2 allocated, responses returned 2,0,1 -> o_itemid order matches table entries for 2,0,1; outstanding reaches 0.
REQ-031 SHALL cover: o_drdy=0 for 5 cycles with two responses pending -> r_drdy=0 after first load, no data lost, both returned in arrival order.
REQ-032 SHALL cover: with SD_SB_INIT_ERRCHK_EN, response r_txid=9 while idle -> o_srdy stays 0, err=1 until reset; reset asserted mid-stream with 4 outstanding -> outstanding=0, p_srdy=0 immediately.
